// File: rtl/cnna_pkg.sv
// Shared helpers for the CNNA buffer blocks.
// Holds the clog2 helper and the legal read-latency range.
package cnna_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/sdpram_be.sv
// One simple dual-port RAM bank: single clock, byte enables,
// one-cycle registered read.
module sdpram_be #(
    parameter string C_MEM_STYLE = "block",
    parameter int    C_DSIZE     = 32,
    parameter int    C_ASIZE     = 10
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic [C_ASIZE-1:0]   I_waddr,
    input  logic [C_DSIZE-1:0]   I_wdata,
    input  logic [C_DSIZE/8-1:0] I_wbe,
    input  logic                 I_wr,
    input  logic [C_ASIZE-1:0]   I_raddr,
    input  logic                 I_rd,
    output logic [C_DSIZE-1:0]   O_rdata
);

    localparam int NB    = C_DSIZE / 8;
    localparam int DEPTH = 1 << C_ASIZE;

    (* ram_style = C_MEM_STYLE *)
    logic [C_DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge I_clk) begin
        if (I_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (I_wbe[i])
                    mem[I_waddr][8*i +: 8] <= I_wdata[8*i +: 8];
            end
        end
    end

    // Output register only (not the array) is reset.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            O_rdata <= '0;
        else if (I_rd)
            O_rdata <= mem[I_raddr];
    end

endmodule

// File: rtl/sdpram_pingpong.sv
// Multi-bank ping-pong buffer built from sdpram_be banks.
// Define SDPRAM_PINGPONG_WBE_EN to expose byte write enables.
module sdpram_pingpong
    import cnna_pkg::*;
#(
    parameter string C_MEM_STYLE = "block",
    parameter int    C_DSIZE     = 32,
    parameter int    C_ASIZE     = 10,
    parameter int    C_BANKS     = 2,
    parameter int    C_RD_LAT    = 1,
    localparam int   BW          = clog2(C_BANKS)
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic [C_ASIZE-1:0]   I_waddr,
    input  logic [C_DSIZE-1:0]   I_wdata,
    input  logic                 I_wr,
`ifdef SDPRAM_PINGPONG_WBE_EN
    input  logic [C_DSIZE/8-1:0] I_wbe,
`endif
    input  logic                 I_wdone,
    output logic                 O_wrdy,
    output logic [BW-1:0]        O_wbank,
    input  logic [C_ASIZE-1:0]   I_raddr,
    input  logic                 I_rd,
    input  logic                 I_rdone,
    output logic                 O_rrdy,
    output logic [BW-1:0]        O_rbank,
    output logic [C_DSIZE-1:0]   O_rdata,
    output logic                 O_rdata_vld,
    output logic [BW:0]          O_full_cnt
);

    if (C_RD_LAT < RD_LAT_MIN || C_RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("sdpram_pingpong: C_RD_LAT must be 1 or 2");
    end

    logic [BW-1:0]        wptr;
    logic [BW-1:0]        rptr;
    logic [BW-1:0]        rbank_q;
    logic [BW:0]          full_cnt;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 wdone_ok;
    logic                 rdone_ok;
    logic                 rd_q;
    logic [C_DSIZE/8-1:0] wbe;
    logic [C_DSIZE-1:0]   bank_dout [C_BANKS];
    logic [C_DSIZE-1:0]   mux_dout;

`ifdef SDPRAM_PINGPONG_WBE_EN
    assign wbe = I_wbe;
`else
    assign wbe = '1;
`endif

    assign O_wrdy     = full_cnt < (BW+1)'(C_BANKS);
    assign O_rrdy     = full_cnt != '0;
    assign O_wbank    = wptr;
    assign O_rbank    = rptr;
    assign O_full_cnt = full_cnt;

    assign wr_ok    = I_wr    && O_wrdy;
    assign rd_ok    = I_rd    && O_rrdy;
    assign wdone_ok = I_wdone && O_wrdy;
    assign rdone_ok = I_rdone && O_rrdy;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            full_cnt <= '0;
        end else begin
            if (wdone_ok)
                wptr <= wptr + 1'b1;
            if (rdone_ok)
                rptr <= rptr + 1'b1;
            case ({wdone_ok, rdone_ok})
                2'b10:   full_cnt <= full_cnt + 1'b1;
                2'b01:   full_cnt <= full_cnt - 1'b1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    // Bank index is latched at issue so a following rdone
    // cannot redirect an in-flight read.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_q    <= 1'b0;
            rbank_q <= '0;
        end else begin
            rd_q <= rd_ok;
            if (rd_ok)
                rbank_q <= rptr;
        end
    end

    for (genvar b = 0; b < C_BANKS; b++) begin : g_bank
        logic wen;
        logic ren;

        assign wen = wr_ok && (wptr == BW'(b));
        assign ren = rd_ok && (rptr == BW'(b));

        sdpram_be #(
            .C_MEM_STYLE (C_MEM_STYLE),
            .C_DSIZE     (C_DSIZE),
            .C_ASIZE     (C_ASIZE)
        ) u_bank (
            .I_clk   (I_clk),
            .I_rst_n (I_rst_n),
            .I_waddr (I_waddr),
            .I_wdata (I_wdata),
            .I_wbe   (wbe),
            .I_wr    (wen),
            .I_raddr (I_raddr),
            .I_rd    (ren),
            .O_rdata (bank_dout[b])
        );
    end

    assign mux_dout = bank_dout[rbank_q];

    if (C_RD_LAT == 1) begin : g_lat1
        assign O_rdata     = mux_dout;
        assign O_rdata_vld = rd_q;
    end else begin : g_lat2
        always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n) begin
                O_rdata     <= '0;
                O_rdata_vld <= 1'b0;
            end else begin
                O_rdata_vld <= rd_q;
                if (rd_q)
                    O_rdata <= mux_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdpram_pingpong.sv
// Bench for sdpram_pingpong: latency-1 and latency-2 instances
// driven in lockstep and compared to a bank/queue model.
module tb_sdpram_pingpong;

    localparam int NBANK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  waddr, raddr;
    logic [31:0] wdata;
    logic        wr, wdone, rd, rdone;
`ifdef SDPRAM_PINGPONG_WBE_EN
    logic [3:0]  wbe;
`endif

    logic        o_wrdy  [2];
    logic        o_rrdy  [2];
    logic [0:0]  o_wbank [2];
    logic [0:0]  o_rbank [2];
    logic [31:0] o_rdata [2];
    logic        o_vld   [2];
    logic [1:0]  o_full  [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdpram_pingpong #(.C_RD_LAT(1)) d1 (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_waddr(waddr), .I_wdata(wdata), .I_wr(wr),
`ifdef SDPRAM_PINGPONG_WBE_EN
        .I_wbe(wbe),
`endif
        .I_wdone(wdone), .O_wrdy(o_wrdy[0]), .O_wbank(o_wbank[0]),
        .I_raddr(raddr), .I_rd(rd), .I_rdone(rdone),
        .O_rrdy(o_rrdy[0]), .O_rbank(o_rbank[0]),
        .O_rdata(o_rdata[0]), .O_rdata_vld(o_vld[0]),
        .O_full_cnt(o_full[0])
    );

    sdpram_pingpong #(.C_RD_LAT(2)) d2 (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_waddr(waddr), .I_wdata(wdata), .I_wr(wr),
`ifdef SDPRAM_PINGPONG_WBE_EN
        .I_wbe(wbe),
`endif
        .I_wdone(wdone), .O_wrdy(o_wrdy[1]), .O_wbank(o_wbank[1]),
        .I_raddr(raddr), .I_rd(rd), .I_rdone(rdone),
        .O_rrdy(o_rrdy[1]), .O_rbank(o_rbank[1]),
        .O_rdata(o_rdata[1]), .O_rdata_vld(o_vld[1]),
        .O_full_cnt(o_full[1])
    );

    // Reference model: plain arrays plus a queue of pending reads.
    typedef struct {
        int          due;
        int          lat;
        logic [31:0] d;
    } rd_t;

    logic [31:0] m_mem [NBANK][1024];
    rd_t         pq[$];
    int          m_wb, m_rb, m_full, e;
    logic        m_vld  [2];
    logic [31:0] m_last [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cur_wbe();
`ifdef SDPRAM_PINGPONG_WBE_EN
        return wbe;
`else
        return 4'hF;
`endif
    endfunction

    task automatic model_reset();
        m_wb = 0;
        m_rb = 0;
        m_full = 0;
        pq.delete();
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 1'b0;
            m_last[k] = '0;
        end
    endtask

    task automatic model_step();
        bit wrdy, rrdy;
        int wd, rdn;
        logic [3:0] be;
        e++;
        wrdy = m_full < NBANK;
        rrdy = m_full > 0;
        be = cur_wbe();
        if (wr && wrdy)
            for (int i = 0; i < 4; i++)
                if (be[i]) m_mem[m_wb][waddr][8*i +: 8] = wdata[8*i +: 8];
        if (rd && rrdy)
            for (int l = 1; l <= 2; l++)
                pq.push_back('{e + l - 1, l, m_mem[m_rb][raddr]});
        wd  = (wdone && wrdy) ? 1 : 0;
        rdn = (rdone && rrdy) ? 1 : 0;
        m_wb = (m_wb + wd) % NBANK;
        m_rb = (m_rb + rdn) % NBANK;
        m_full = m_full + wd - rdn;
        m_vld[0] = 1'b0;
        m_vld[1] = 1'b0;
        foreach (pq[i])
            if (pq[i].due == e) begin
                m_vld[pq[i].lat-1] = 1'b1;
                m_last[pq[i].lat-1] = pq[i].d;
            end
        for (int i = pq.size() - 1; i >= 0; i--)
            if (pq[i].due <= e) pq.delete(i);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wrdy%0d", k), 32'(o_wrdy[k]), 32'(m_full < NBANK));
            chk($sformatf("rrdy%0d", k), 32'(o_rrdy[k]), 32'(m_full > 0));
            chk($sformatf("wbank%0d", k), 32'(o_wbank[k]), m_wb);
            chk($sformatf("rbank%0d", k), 32'(o_rbank[k]), m_rb);
            chk($sformatf("full%0d", k), 32'(o_full[k]), m_full);
            chk($sformatf("vld%0d", k), 32'(o_vld[k]), 32'(m_vld[k]));
            chk($sformatf("rdata%0d", k), o_rdata[k], m_last[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        wr = 0; wdone = 0; rd = 0; rdone = 0;
`ifdef SDPRAM_PINGPONG_WBE_EN
        wbe = 4'hF;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] b1_0;

    initial begin
        e = 0;
        waddr = '0; raddr = '0; wdata = '0;
        do_reset();

        // Fill bank 0 with data = addr
        for (int a = 0; a < 1024; a++) begin
            wr = 1; waddr = 10'(a); wdata = 32'(a);
            tick();
        end
        wr = 0; wdone = 1;
        tick();
        wdone = 0;
        chk("wbank_after_fill", 32'(o_wbank[0]), 1);
        chk("full_after_fill", 32'(o_full[0]), 1);
        chk("rrdy_after_fill", 32'(o_rrdy[0]), 1);

        rd = 1; raddr = 10'd5;
        tick();
        rd = 0;
        chk("lat1_vld", 32'(o_vld[0]), 1);
        chk("lat1_data5", o_rdata[0], 5);
        chk("lat2_early", 32'(o_vld[1]), 0);
        tick();
        chk("lat2_vld", 32'(o_vld[1]), 1);
        chk("lat2_data5", o_rdata[1], 5);
        chk("lat1_pulse", 32'(o_vld[0]), 0);

        // Fill bank 1, then both banks full
        for (int a = 0; a < 1024; a++) begin
            wr = 1; waddr = 10'(a); wdata = $urandom;
            if (a == 0) b1_0 = wdata;
            tick();
        end
        wr = 0; wdone = 1;
        tick();
        wdone = 0;
        chk("wrdy_when_full", 32'(o_wrdy[0]), 0);
        chk("full_cnt_2", 32'(o_full[1]), 2);

        wr = 1; waddr = 0; wdata = 32'hDEAD;
        tick();
        wr = 0; rd = 1; raddr = 0;
        tick();
        rd = 0;
        tick();
        chk("bank0_kept", o_rdata[1], 0);
        rdone = 1;
        tick();
        rdone = 0; rd = 1; raddr = 0;
        tick();
        rd = 0;
        tick();
        chk("bank1_kept", o_rdata[1], b1_0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            wr = 1'($urandom_range(0, 1));
            waddr = 10'($urandom);
            wdata = $urandom;
            rd = 1'($urandom_range(0, 1));
            raddr = 10'($urandom);
            wdone = ($urandom_range(0, 15) == 0);
            rdone = ($urandom_range(0, 15) == 0);
`ifdef SDPRAM_PINGPONG_WBE_EN
            wbe = 4'($urandom);
`endif
            tick();
        end
        idle();
        tick();

        // Simultaneous wdone and rdone with one full bank
        do_reset();
        for (int a = 0; a < 4; a++) begin
            wr = 1; waddr = 10'(a); wdata = $urandom;
            tick();
        end
        wr = 0; wdone = 1;
        tick();
        rdone = 1;
        tick();
        idle();
        chk("both_full", 32'(o_full[0]), 1);
        chk("both_wbank", 32'(o_wbank[0]), 0);
        chk("both_rbank", 32'(o_rbank[0]), 1);

        // Read from bank 0 then release it the next cycle
        do_reset();
        wr = 1; waddr = 10'd7; wdata = 32'h1234_5678;
        tick();
        wr = 0; wdone = 1;
        tick();
        wdone = 0; rd = 1; raddr = 10'd7;
        tick();
        rd = 0; rdone = 1;
        tick();
        rdone = 0;
        chk("inflight_vld", 32'(o_vld[1]), 1);
        chk("inflight_data", o_rdata[1], 32'h1234_5678);
        chk("inflight_rbank", 32'(o_rbank[1]), 1);

`ifdef SDPRAM_PINGPONG_WBE_EN
        wr = 1; waddr = 10'd9; wdata = 32'hFFFF_FFFF; wbe = 4'hF;
        tick();
        wdata = 32'h0; wbe = 4'b0101;
        tick();
        wr = 0; wbe = 4'hF; wdone = 1;
        tick();
        wdone = 0; rd = 1; raddr = 10'd9;
        tick();
        rd = 0;
        tick();
        chk("wbe_merge", o_rdata[1], 32'hFF00_FF00);
        rdone = 1;
        tick();
        rdone = 0;
`endif

        // Reset landing on an in-flight read
        wr = 1; waddr = 10'd3; wdata = 32'hA5A5_0003;
        tick();
        wr = 0; wdone = 1;
        tick();
        wdone = 0; rd = 1; raddr = 10'd3;
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check_all();
        tick();
        chk("rst_vld1", 32'(o_vld[0]), 0);
        chk("rst_vld2", 32'(o_vld[1]), 0);
        chk("rst_full", 32'(o_full[1]), 0);
        chk("rst_wbank", 32'(o_wbank[1]), 0);
        chk("rst_rbank", 32'(o_rbank[1]), 0);
        rst_n = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
